if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage in-order MIPS pipeline. Sits directly upstream of the decode stage.
- Generates the fetch PC (pre-IF) and drives a synchronous instruction SRAM with 1-cycle read latency.
- Holds the fetched instruction with PC/NPC/NNPC until decode accepts it, using a valid/allowin handshake.
- Applies branch/jump redirects resolved in decode, honouring the single delay slot.

---
 rtl/if_stage.sv | 70 +++++++
 tb/tb_if_stage.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: pre-IF PC generation, synchronous I-SRAM read,
// and a one-entry instruction hold for the valid/allowin handshake with decode.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_allowin_in,
  input  logic        id_valid_in,
  input  logic        id_br_taken_in,
  input  logic [31:0] id_br_target_in,
  output logic        if_valid_out,
  output logic [31:0] if_PC_out,
  output logic [31:0] if_NPC_out,
  output logic [31:0] if_NNPC_out,
  output logic [31:0] if_Instruct_out,
  output logic        if_adel_out,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  logic [31:0] pc_r;
  logic [31:0] inst_buf;
  logic [31:0] nextpc;
  logic        if_valid_r;
  logic        fresh_r;
  logic        adel_r;
  logic        if_allowin;
  logic        br_ev;

  assign if_allowin = !if_valid_r || id_allowin_in;
  // A branch leaving decode redirects the fetch after the delay slot in IF.
  assign br_ev      = id_valid_in && id_allowin_in && id_br_taken_in;
  assign nextpc     = br_ev ? id_br_target_in : pc_r + 32'd4;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r       <= RESET_PC - 32'd4;
      if_valid_r <= 1'b0;
      fresh_r    <= 1'b0;
      inst_buf   <= 32'b0;
      adel_r     <= 1'b0;
    end else if (if_allowin) begin
      pc_r       <= nextpc;
      if_valid_r <= 1'b1;
      adel_r     <= (nextpc[1:0] != 2'b00);
      fresh_r    <= 1'b1;
    end else if (fresh_r) begin
      // Stalled: capture the SRAM word once, since rdata may change later.
      inst_buf   <= inst_sram_rdata;
      fresh_r    <= 1'b0;
    end
  end

  assign inst_sram_en    = if_allowin && rst_n && (nextpc[1:0] == 2'b00);
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wen   = 4'b0;
  assign inst_sram_wdata = 32'b0;

  assign if_valid_out    = if_valid_r;
  assign if_PC_out       = pc_r;
  assign if_NPC_out      = pc_r + 32'd4;
  assign if_NNPC_out     = pc_r + 32'd8;
  assign if_adel_out     = adel_r;
  assign if_Instruct_out = adel_r ? 32'b0 : (fresh_r ? inst_sram_rdata : inst_buf);

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: SRAM model, reference PC model and a
// scoreboard of issued PCs popped when decode accepts an instruction.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_allowin_in, id_valid_in, id_br_taken_in;
  logic [31:0] id_br_target_in;
  logic        if_valid_out, if_adel_out, inst_sram_en;
  logic [31:0] if_PC_out, if_NPC_out, if_NNPC_out, if_Instruct_out;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
  logic [31:0] rdata_q;
  logic        garbage;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_allowin_in(id_allowin_in), .id_valid_in(id_valid_in),
    .id_br_taken_in(id_br_taken_in), .id_br_target_in(id_br_target_in),
    .if_valid_out(if_valid_out), .if_PC_out(if_PC_out),
    .if_NPC_out(if_NPC_out), .if_NNPC_out(if_NNPC_out),
    .if_Instruct_out(if_Instruct_out), .if_adel_out(if_adel_out),
    .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  always @(posedge clk) if (inst_sram_en) rdata_q <= word(inst_sram_addr);
  assign inst_sram_rdata = garbage ? 32'hDEAD_BEEF : rdata_q;

  always @(posedge clk)
    if (rst_n && id_valid_in && id_allowin_in && id_br_taken_in)
      assert (if_valid_out) else $error("FAIL br_ev_without_valid: got 0 expected 1");

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs at negedge, check against the model, advance model.
  task automatic step(input logic allow, input logic vld, input logic tk, input logic [31:0] tgt);
    logic        m_allow, m_br;
    logic [31:0] npc, hp;
    id_allowin_in = allow; id_valid_in = vld; id_br_taken_in = tk; id_br_target_in = tgt;
    #1;
    m_allow = !m_valid || allow;
    m_br    = vld && allow && tk;
    npc     = m_br ? tgt : m_pc + 32'd4;
    check_val("sram_en", {31'b0, inst_sram_en}, {31'b0, m_allow && (npc[1:0] == 2'b00)});
    if (m_allow && npc[1:0] == 2'b00) check_val("sram_addr", inst_sram_addr, npc);
    check_val("valid", {31'b0, if_valid_out}, {31'b0, m_valid});
    if (m_valid && q.size() > 0) begin
      hp = q[0];
      check_val("pc", if_PC_out, hp);
      check_val("npc", if_NPC_out, hp + 32'd4);
      check_val("nnpc", if_NNPC_out, hp + 32'd8);
      check_val("adel", {31'b0, if_adel_out}, {31'b0, hp[1:0] != 2'b00});
      check_val("instr", if_Instruct_out, (hp[1:0] != 2'b00) ? 32'b0 : word(hp));
      if (allow) void'(q.pop_front());
    end
    if (m_allow) begin
      q.push_back(npc);
      m_pc    = npc;
      m_valid = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    id_allowin_in = 1'b0; id_valid_in = 1'b0; id_br_taken_in = 1'b0; id_br_target_in = 32'b0;
    #1;
    check_val("rst_sram_en", {31'b0, inst_sram_en}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_val("rst_valid", {31'b0, if_valid_out}, 32'd0);
    check_val("rst_pc", if_PC_out, RESET_PC - 32'd4);
    check_val("rst_instr", if_Instruct_out, 32'b0);
    check_val("rst_adel", {31'b0, if_adel_out}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    m_pc    = RESET_PC - 32'd4;
    m_valid = 1'b0;
    q.delete();
    rst_n   = 1'b1;
  endtask

  initial begin
    garbage = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);
    do_reset();
    check_val("wen_tied", {28'b0, inst_sram_wen}, 32'd0);
    check_val("wdata_tied", inst_sram_wdata, 32'd0);

    // Free-run: issues 00, 04, 08; IF then holds 08.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    // Stall 3 cycles with SRAM data corrupted after the first.
    step(0, 0, 0, 0);
    garbage = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    garbage = 1'b0;
    step(1, 0, 0, 0);                     // resume issues 0C
    step(1, 0, 0, 0);                     // IF holds 10
    step(1, 1, 1, 32'hBFC0_0100);          // delay slot 10 leaves, issue 100
    step(1, 1, 1, 32'hBFC0_0102);          // misaligned target, no SRAM read
    step(1, 0, 0, 0);                     // IF presents 102 with adel
    step(1, 1, 1, 32'hFFFF_FFFC);          // redirect near top of address space
    step(1, 0, 0, 0);                     // wrap to 0
    step(1, 1, 1, 32'hBFC0_0200);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    do_reset();                           // reset while stalled
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // Random stress against the model.
    for (int i = 0; i < 400; i++) begin
      logic        a, v, t;
      logic [31:0] tg;
      a  = ($urandom_range(0, 3) != 0);
      v  = ($urandom_range(0, 1) == 1);
      t  = m_valid && ($urandom_range(0, 4) == 0);
      tg = {16'hBFC0, 14'($urandom_range(0, 16383)), 2'b00};
      if ($urandom_range(0, 7) == 0) tg[1:0] = 2'($urandom_range(1, 3));
      step(a, v, t, tg);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
